// File: rtl/leitor_serial.sv
// rtl/leitor_serial.sv - parallel-in, serial-out reader with valid strobe and done pulse
module leitor_serial #(
  parameter int LARGURA      = 16,
  parameter bit MSB_PRIMEIRO = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] valor,
  input  logic               inicio,
  output logic               saida_serial,
  output logic               bit_valido,
  output logic               ocupado,
  output logic               pronto
);

  localparam int CW = $clog2(LARGURA + 1);
  localparam logic [CW-1:0] CNT_INI = CW'(LARGURA - 1);

  typedef enum logic [1:0] {
    OCIOSO,
    DESLOCA,
    FIM
  } estado_t;

  estado_t            estado;
  logic [LARGURA-1:0] desloc;
  logic [CW-1:0]      cont;
  logic [LARGURA-1:0] prox;

  // The bit on the wire is always the head of the shift register, so the
  // next bit is the head of the shifted word.
  function automatic logic cabeca(input logic [LARGURA-1:0] w);
    return MSB_PRIMEIRO ? w[LARGURA-1] : w[0];
  endfunction

  assign prox = MSB_PRIMEIRO ? (desloc << 1) : (desloc >> 1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado       <= OCIOSO;
      desloc       <= '0;
      cont         <= '0;
      saida_serial <= 1'b0;
      bit_valido   <= 1'b0;
      ocupado      <= 1'b0;
      pronto       <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          pronto <= 1'b0;
          if (inicio) begin
            desloc       <= valor;
            cont         <= CNT_INI;
            saida_serial <= cabeca(valor);
            bit_valido   <= 1'b1;
            ocupado      <= 1'b1;
            estado       <= DESLOCA;
          end
        end
        DESLOCA: begin
          if (cont != '0) begin
            desloc       <= prox;
            saida_serial <= cabeca(prox);
            cont         <= cont - CW'(1);
          end else begin
            saida_serial <= 1'b0;
            bit_valido   <= 1'b0;
            ocupado      <= 1'b0;
            pronto       <= 1'b1;
            estado       <= FIM;
          end
        end
        FIM: begin
          pronto <= 1'b0;
          estado <= OCIOSO;
        end
        default: begin
          estado <= OCIOSO;
        end
      endcase
    end
  end

endmodule
